// File: rtl/stage_sequencer_pkg.sv
// rtl/stage_sequencer_pkg.sv - shared stage encodings, instruction field positions and helpers
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_S0   = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_HALT = 3'd4
  } stage_e;

  // Field positions within the 32-bit instruction word.
  localparam int ALU_OP_LSB     = 24;
  localparam int OP_V1_CONST_BIT = 26;
  localparam int OP_HALT_BIT    = 27;
  localparam int OP_JNZ_BIT     = 28;
  localparam int OP_TO_RAM_BIT  = 29;
  localparam int V0_LSB         = 16;
  localparam int V1_LSB         = 8;
  localparam int V2_LSB         = 0;

  localparam logic [15:0] PC_STEP_DEFAULT = 16'd4;

  function automatic logic [15:0] zext8(input logic [7:0] b);
    return {8'h00, b};
  endfunction

  function automatic logic [3:0] stage_onehot(input stage_e s);
    case (s)
      ST_S0:   return 4'b0001;
      ST_S1:   return 4'b0010;
      ST_S2:   return 4'b0100;
      ST_S3:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - memory/ALU handshake bundle between sequencer and address mux
interface stage_sequencer_if;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] alu_result;
  logic        execute_from_brom;
  logic [3:0]  is_stage;
  logic [3:0]  is_write;
  logic        mem_valid;
  logic [15:0] address0;
  logic [15:0] address1;
  logic [15:0] address2;
  logic [15:0] address3;
  logic [1:0]  alu_op;
  logic [31:0] v1_value;
  logic [31:0] v2_value;
  logic [31:0] mem_wdata;
  logic        halted;

  modport master (
    input  mem_ready, mem_rdata, alu_result,
    output execute_from_brom, is_stage, is_write, mem_valid,
           address0, address1, address2, address3,
           alu_op, v1_value, v2_value, mem_wdata, halted
  );

  modport slave (
    output mem_ready, mem_rdata, alu_result,
    input  execute_from_brom, is_stage, is_write, mem_valid,
           address0, address1, address2, address3,
           alu_op, v1_value, v2_value, mem_wdata, halted
  );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - four-stage fetch/operand/write-back sequencer with PC and BROM/RAM select
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter logic [15:0] PC_STEP   = PC_STEP_DEFAULT,
  parameter bit          BOOT_BROM = 1'b1
) (
  input logic               clk,
  input logic               reset,
  stage_sequencer_if.master bus
);

  stage_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, pc_inc;
  logic [31:0] instr_q, instr_d;
  logic [31:0] v1_q, v1_d;
  logic [31:0] v2_q, v2_d;
  logic        brom_q, brom_d;
  logic        mem_valid;
  logic [3:0]  is_write;
  logic        unused_op_bits;

  assign pc_inc = pc_q + PC_STEP;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    brom_d    = brom_q;
    mem_valid = 1'b0;
    is_write  = 4'b0000;
    case (state_q)
      ST_S0: begin
        mem_valid = 1'b1;
        if (bus.mem_ready) begin
          instr_d = bus.mem_rdata;
          state_d = bus.mem_rdata[OP_HALT_BIT] ? ST_HALT : ST_S1;
        end
      end
      ST_S1: begin
        if (instr_q[OP_V1_CONST_BIT]) begin
          v1_d    = {24'h0, instr_q[V1_LSB +: 8]};
          state_d = ST_S2;
        end else begin
          mem_valid = 1'b1;
          if (bus.mem_ready) begin
            v1_d    = bus.mem_rdata;
            state_d = ST_S2;
          end
        end
      end
      ST_S2: begin
        mem_valid = 1'b1;
        if (bus.mem_ready) begin
          v2_d    = bus.mem_rdata;
          state_d = ST_S3;
        end
      end
      ST_S3: begin
        // TO_RAM outranks JNZ, which outranks the normal write-back
        if (instr_q[OP_TO_RAM_BIT]) begin
          brom_d  = 1'b0;
          pc_d    = 16'h0000;
          state_d = ST_S0;
        end else if (instr_q[OP_JNZ_BIT]) begin
          pc_d    = (v1_q != 32'h0) ? zext8(instr_q[V0_LSB +: 8]) : pc_inc;
          state_d = ST_S0;
        end else begin
          mem_valid = 1'b1;
          is_write  = reset ? 4'b0000 : 4'b1000;
          if (bus.mem_ready) begin
            pc_d    = pc_inc;
            state_d = ST_S0;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_S0;
      pc_q    <= 16'h0000;
      instr_q <= 32'h0;
      v1_q    <= 32'h0;
      v2_q    <= 32'h0;
      brom_q  <= BOOT_BROM;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      brom_q  <= brom_d;
    end
  end

  assign bus.execute_from_brom = brom_q;
  assign bus.is_stage          = stage_onehot(state_q);
  assign bus.is_write          = is_write;
  assign bus.mem_valid         = mem_valid;
  assign bus.address0          = pc_q;
  assign bus.address1          = zext8(instr_q[V0_LSB +: 8]);
  assign bus.address2          = zext8(instr_q[V1_LSB +: 8]);
  assign bus.address3          = zext8(instr_q[V2_LSB +: 8]);
  assign bus.alu_op            = instr_q[ALU_OP_LSB +: 2];
  assign bus.v1_value          = v1_q;
  assign bus.v2_value          = v2_q;
  assign bus.mem_wdata         = is_write[3] ? bus.alu_result : 32'h0;
  assign bus.halted            = (state_q == ST_HALT);

  assign unused_op_bits = ^instr_q[31:30];

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed literal checks plus randomized program run against an instruction-level model
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stage_sequencer_if bus ();

  stage_sequencer #(.PC_STEP(16'd4), .BOOT_BROM(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_op, bus.v1_value, bus.v2_value);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit rdy, input logic [31:0] d);
    bus.mem_ready = rdy;
    bus.mem_rdata = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Instruction-level reference model: each instruction expands into its bus steps.
  typedef struct {
    int          stage;
    bit          valid;
    bit          wr;
    bit          halt_after;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
  } step_t;

  step_t       q[$];
  logic [31:0] prog [logic [16:0]];
  logic [31:0] data_mem [256];
  logic [15:0] m_pc, m_next_pc;
  logic        m_brom, m_next_brom, m_halted;
  int          halt_cnt;

  function automatic logic [31:0] gen_instr();
    logic [7:0] op;
    op[1:0] = 2'($urandom);
    op[2]   = 1'($urandom);
    op[3]   = ($urandom_range(0, 49) == 0);
    op[4]   = ($urandom_range(0, 3) == 0);
    op[5]   = ($urandom_range(0, 29) == 0);
    op[7:6] = 2'($urandom);
    return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  function automatic logic [31:0] fetch_model(input logic brom, input logic [15:0] pc);
    if (!prog.exists({brom, pc})) prog[{brom, pc}] = gen_instr();
    return prog[{brom, pc}];
  endfunction

  task automatic build_instr();
    step_t       s;
    logic [31:0] ins, v1, v2;
    ins = fetch_model(m_brom, m_pc);
    s = '{stage: 0, valid: 1'b1, wr: 1'b0, halt_after: ins[27], addr: m_pc,
          wdata: 32'h0, rdata: ins, op: ins[25:24], v1: 32'h0, v2: 32'h0};
    q.push_back(s);
    if (ins[27]) return;
    v1 = ins[26] ? {24'h0, ins[15:8]} : data_mem[ins[15:8]];
    v2 = data_mem[ins[7:0]];
    s = '{stage: 1, valid: !ins[26], wr: 1'b0, halt_after: 1'b0, addr: {8'h0, ins[15:8]},
          wdata: 32'h0, rdata: v1, op: ins[25:24], v1: 32'h0, v2: 32'h0};
    q.push_back(s);
    s = '{stage: 2, valid: 1'b1, wr: 1'b0, halt_after: 1'b0, addr: {8'h0, ins[7:0]},
          wdata: 32'h0, rdata: v2, op: ins[25:24], v1: v1, v2: 32'h0};
    q.push_back(s);
    s = '{stage: 3, valid: 1'b0, wr: 1'b0, halt_after: 1'b0, addr: {8'h0, ins[23:16]},
          wdata: alu_f(ins[25:24], v1, v2), rdata: 32'h0, op: ins[25:24], v1: v1, v2: v2};
    m_next_brom = m_brom;
    if (ins[29]) begin
      m_next_pc   = 16'h0;
      m_next_brom = 1'b0;
    end else if (ins[28]) begin
      m_next_pc = (v1 != 0) ? {8'h0, ins[23:16]} : m_pc + 16'd4;
    end else begin
      s.valid   = 1'b1;
      s.wr      = 1'b1;
      m_next_pc = m_pc + 16'd4;
    end
    q.push_back(s);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = 16'h0;
    m_brom   = 1'b1;
    m_halted = 1'b0;
    halt_cnt = 0;
  endtask

  task automatic random_phase(input int ncycles);
    step_t h;
    bit    rst_now, rdy, acc;
    prog.delete();
    for (int i = 0; i < 256; i++)
      data_mem[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
    reset = 1'b1;
    cyc(1'b0, 32'h0);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < ncycles; c++) begin
      rst_now = ($urandom_range(0, 299) == 0) || (m_halted && halt_cnt > 3);
      if (!m_halted && q.size() == 0) build_instr();
      rdy = ($urandom_range(0, 99) < 65);
      h = m_halted ? h : q[0];
      acc = !m_halted && h.valid && rdy;
      reset = rst_now;
      bus.mem_ready = rdy;
      bus.mem_rdata = acc ? h.rdata : $urandom;
      #1;
      chk("rnd_brom", 32'(bus.execute_from_brom), 32'(m_brom));
      chk("rnd_pc", 32'(bus.address0), 32'(m_pc));
      if (m_halted) begin
        chk("rnd_halt_stage", 32'(bus.is_stage), 32'h0);
        chk("rnd_halt_valid", 32'(bus.mem_valid), 32'h0);
        chk("rnd_halted", 32'(bus.halted), 32'h1);
      end else begin
        chk("rnd_stage", 32'(bus.is_stage), 32'(4'b0001 << h.stage));
        chk("rnd_valid", 32'(bus.mem_valid), 32'(h.valid));
        chk("rnd_halted", 32'(bus.halted), 32'h0);
        chk("rnd_is_write", 32'(bus.is_write), (h.wr && !rst_now) ? 32'h8 : 32'h0);
        chk("rnd_wdata", bus.mem_wdata, (h.wr && !rst_now) ? h.wdata : 32'h0);
        if (h.stage == 1 && h.valid) chk("rnd_addr2", 32'(bus.address2), 32'(h.addr));
        if (h.stage == 2) chk("rnd_addr3", 32'(bus.address3), 32'(h.addr));
        if (h.stage >= 2) chk("rnd_v1", bus.v1_value, h.v1);
        if (h.stage == 3) begin
          chk("rnd_v2", bus.v2_value, h.v2);
          chk("rnd_alu_op", 32'(bus.alu_op), 32'(h.op));
          if (h.wr) chk("rnd_addr1", 32'(bus.address1), 32'(h.addr));
        end
      end
      @(posedge clk);
      if (rst_now) begin
        model_reset();
      end else if (m_halted) begin
        halt_cnt++;
      end else if (!h.valid || rdy) begin
        void'(q.pop_front());
        if (h.wr) data_mem[h.addr[7:0]] = h.wdata;
        if (h.halt_after) m_halted = 1'b1;
        else if (q.size() == 0) begin
          m_pc   = m_next_pc;
          m_brom = m_next_brom;
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  int wraps;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pc", 32'(bus.address0), 32'h0);
    chk("rst_brom", 32'(bus.execute_from_brom), 32'h1);
    chk("rst_stage", 32'(bus.is_stage), 32'h1);
    chk("rst_valid", 32'(bus.mem_valid), 32'h1);
    chk("rst_write", 32'(bus.is_write), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);

    // Zero-wait normal instruction: sub 5-3 written to 0x10.
    cyc(1'b1, 32'h01_10_20_30);
    chk("s1_stage", 32'(bus.is_stage), 32'h2);
    chk("s1_addr2", 32'(bus.address2), 32'h20);
    chk("s1_valid", 32'(bus.mem_valid), 32'h1);
    cyc(1'b1, 32'h5);
    chk("s2_addr3", 32'(bus.address3), 32'h30);
    chk("s2_v1", bus.v1_value, 32'h5);
    cyc(1'b1, 32'h3);
    chk("s3_write", 32'(bus.is_write), 32'h8);
    chk("s3_addr1", 32'(bus.address1), 32'h10);
    chk("s3_wdata", bus.mem_wdata, 32'h2);
    cyc(1'b1, 32'h0);
    chk("pc_after4", 32'(bus.address0), 32'h4);
    chk("s0_again", 32'(bus.is_stage), 32'h1);

    // Same instruction with a three-cycle stall in S2.
    cyc(1'b1, 32'h01_10_20_30);
    cyc(1'b1, 32'h7);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'hDEAD_0000 + 32'(i));
      chk("stall_stage", 32'(bus.is_stage), 32'h4);
      chk("stall_v2", bus.v2_value, 32'h3);
      chk("stall_pc", 32'(bus.address0), 32'h4);
    end
    cyc(1'b1, 32'h9);
    chk("stall_s3", 32'(bus.is_stage), 32'h8);
    chk("stall_wdata", bus.mem_wdata, 32'hFFFF_FFFE);
    cyc(1'b1, 32'h0);
    chk("stall_pc8", 32'(bus.address0), 32'h8);

    // JNZ taken via memory operand, then not taken via constant zero.
    cyc(1'b1, 32'h10_40_11_22);
    cyc(1'b1, 32'h1);
    cyc(1'b1, 32'h0);
    chk("jnz_valid", 32'(bus.mem_valid), 32'h0);
    chk("jnz_write", 32'(bus.is_write), 32'h0);
    cyc(1'b1, 32'h0);
    chk("jnz_taken", 32'(bus.address0), 32'h40);
    cyc(1'b1, 32'h14_80_00_05);
    chk("const_valid", 32'(bus.mem_valid), 32'h0);
    cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h0);
    chk("jnz_nt_write", 32'(bus.is_write), 32'h0);
    cyc(1'b1, 32'h0);
    chk("jnz_not_taken", 32'(bus.address0), 32'h44);

    // March the PC to 0xFFFC with 4-cycle JNZ-not-taken instructions.
    wraps = 0;
    while (!(bus.is_stage == 4'b0001 && bus.address0 == 16'hFFFC) && wraps < 70000) begin
      cyc(1'b1, 32'h14_00_00_00);
      wraps++;
    end
    chk("march_cycles", 32'(wraps), 32'd65464);
    cyc(1'b1, 32'h00_11_22_33);
    cyc(1'b1, 32'h1);
    cyc(1'b1, 32'h2);
    chk("wrap_wdata", bus.mem_wdata, 32'h3);
    chk("wrap_addr1", 32'(bus.address1), 32'h11);
    cyc(1'b1, 32'h0);
    chk("pc_wrap", 32'(bus.address0), 32'h0);

    // TO_RAM: no access in S3, then RAM fetch from 0.
    cyc(1'b1, 32'h20_00_00_00);
    cyc(1'b1, 32'h0);
    cyc(1'b1, 32'h0);
    chk("toram_valid", 32'(bus.mem_valid), 32'h0);
    chk("toram_write", 32'(bus.is_write), 32'h0);
    cyc(1'b1, 32'h0);
    chk("toram_brom", 32'(bus.execute_from_brom), 32'h0);
    chk("toram_pc", 32'(bus.address0), 32'h0);

    // HALT.
    cyc(1'b1, 32'h08_00_00_00);
    cyc(1'b1, 32'h0);
    chk("halt_flag", 32'(bus.halted), 32'h1);
    chk("halt_stage", 32'(bus.is_stage), 32'h0);
    chk("halt_valid", 32'(bus.mem_valid), 32'h0);
    reset = 1'b1;
    cyc(1'b1, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_brom_back", 32'(bus.execute_from_brom), 32'h1);
    chk("rst_unhalt", 32'(bus.halted), 32'h0);

    // Reset during an S2 stall.
    cyc(1'b1, 32'h01_10_20_30);
    cyc(1'b1, 32'h5);
    cyc(1'b0, 32'h0);
    reset = 1'b1;
    cyc(1'b1, 32'h6);
    reset = 1'b0;
    #1;
    chk("rst_stall_stage", 32'(bus.is_stage), 32'h1);
    chk("rst_stall_pc", 32'(bus.address0), 32'h0);
    chk("rst_stall_v2", bus.v2_value, 32'h0);
    chk("rst_stall_write", 32'(bus.is_write), 32'h0);

    // Reset while S3 write is ready: no write strobe, PC stays 0.
    cyc(1'b1, 32'h00_10_20_30);
    cyc(1'b1, 32'h5);
    cyc(1'b1, 32'h6);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_s3_write", 32'(bus.is_write), 32'h0);
    chk("rst_s3_wdata", bus.mem_wdata, 32'h0);
    cyc(1'b1, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_s3_pc", 32'(bus.address0), 32'h0);

    random_phase(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
